dir_validator: RTL and testbench
================================

DIR_VALIDATOR -- requirements
Module: dir_validator

Interface
REQ-001 SHALL have parameters: BOARD_CELLS, default 100, number of cells in the bordered 10x10 board memory; MAX_WALK, default 8, maximum cells examined per walk.
REQ-002 SHALL have ports: clock  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  active-low reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports: ld  in  1  load request for step/start/player registers.
REQ-005 SHALL have ports: enable  in  1  start walk, one-cycle pulse from the move controller.
REQ-006 SHALL have ports: step_in  in  8  signed two's-complement address step (-10 up, +10 down, -1 left, +1 right).
REQ-007 SHALL have ports: e_addr_in  in  7  start cell address (row*10+col).
REQ-008 SHALL have ports: player_in  in  2  moving player (01 black, 10 white).
REQ-009 SHALL have ports: mem_data_in  in  2  board cell read data (00 empty, 01 black, 10 white, 11 border), valid one cycle after mem_addr_o.
REQ-010 SHALL have ports: mem_addr_o  out  7  registered board read address.
REQ-011 SHALL have ports: s_done_o  out  1  one-cycle walk-complete pulse.
REQ-012 SHALL have ports: dir_status_o  out  1  direction valid (captures at least one opponent piece).
REQ-013 SHALL have ports: flip_cnt_o  out  3  count of opponent pieces bracketed; valid with s_done_o.

Function
REQ-014 SHALL implement states IDLE, WAIT, CHECK, DONE.
REQ-015 In IDLE with ld=1, SHALL register step_in, e_addr_in, player_in; ld outside IDLE ignored.
REQ-016 In IDLE with enable=1: SHALL compute next = cur + step (9-bit signed, cur = loaded start); if next in 0..BOARD_CELLS-1, mem_addr_o <= next, cell counter <= 0, opp count <= 0, go WAIT; else go DONE with result 0.
REQ-017 ld and enable in same IDLE cycle: SHALL load first, walk uses newly loaded values.
REQ-018 enable outside IDLE SHALL be ignored.
REQ-019 WAIT: one cycle, unconditional -> CHECK.
REQ-020 CHECK decodes mem_data_in; opponent = player_in XOR 11.
REQ-021 CHECK, cell == opponent: opp count +1; if cell counter+1 == MAX_WALK or next address out of range -> DONE result 0; else mem_addr_o <= mem_addr_o + step, counter +1, -> WAIT.
REQ-022 CHECK, cell == player and opp count >= 1: -> DONE, dir_status_o <= 1, flip_cnt_o <= opp count.
REQ-023 CHECK, cell empty, border, or player with opp count 0: -> DONE, dir_status_o <= 0, flip_cnt_o <= 0.
REQ-024 Loaded player 00 or 11: SHALL go IDLE -> DONE directly, no memory reads, result 0.
REQ-025 DONE: s_done_o = 1 for exactly this cycle, -> IDLE.
REQ-026 dir_status_o and flip_cnt_o SHALL hold from DONE until next accepted enable, then clear to 0.
REQ-027 Latency: enable at edge k, first cell decisive -> s_done_o high in cycle after edge k+3; each extra cell adds 2 cycles.
REQ-028 mem_addr_o SHALL hold its value when not advancing.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, mem_addr_o=0, s_done_o=0, dir_status_o=0, flip_cnt_o=0, loaded step/start/player=0, counters=0.
REQ-030 Reset mid-walk SHALL abort with no s_done_o pulse; next walk needs new ld and enable.

Verification
REQ-031 ld start=44, step=+1, player=01; cells 45=10, 46=01; enable -> mem_addr 45 then 46, s_done once, dir_status=1, flip_cnt=1, 5 cycles after enable.
REQ-032 start=44, step=-10, player=10; 34=00 -> s_done after 3 cycles, dir_status=0, flip_cnt=0.
REQ-033 start=11, step=-1, player=01; 10=11 border -> dir_status=0; start=5, step=-10 -> DONE without read, dir_status=0.
REQ-034 start=81, step=-10, player=01; 71..21=10, 11=01 -> dir_status=1, flip_cnt=6; with 11=10 -> dir_status=0.
REQ-035 reset asserted in WAIT of REQ-031 walk -> all outputs 0 immediately, no s_done; enable during CHECK ignored.
REQ-036 player_in=00 loaded, enable -> s_done next cycle after edge k+1, dir_status=0, no mem_addr_o change.

Source files
------------

// File: rtl/dir_validator.sv
// Walks the board from a start cell along one direction and reports whether the
// walk brackets one or more opponent pieces, and how many.
module dir_validator #(
    parameter int BOARD_CELLS = 100,
    parameter int MAX_WALK    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ld,
    input  logic       enable,
    input  logic [7:0] step_in,
    input  logic [6:0] e_addr_in,
    input  logic [1:0] player_in,
    input  logic [1:0] mem_data_in,
    output logic [6:0] mem_addr_o,
    output logic       s_done_o,
    output logic       dir_status_o,
    output logic [2:0] flip_cnt_o
);

    localparam int            CW        = $clog2(MAX_WALK + 1);
    localparam logic [8:0]    CELLS     = 9'(BOARD_CELLS);
    localparam logic [CW-1:0] WALK_LAST = CW'(MAX_WALK - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    step_q, step_d;
    logic [6:0]    start_q, start_d;
    logic [1:0]    player_q, player_d;
    logic [6:0]    addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] opp_q, opp_d;
    logic          status_d;
    logic [2:0]    flip_d;
    logic          done_d;

    logic          load_now;
    logic [8:0]    base;
    logic [8:0]    nxt;
    logic          nxt_ok;
    logic          player_ok;
    logic [1:0]    opponent;

    always_comb begin
        load_now  = (state_q == IDLE) && ld;
        step_d    = load_now ? step_in   : step_q;
        start_d   = load_now ? e_addr_in : start_q;
        player_d  = load_now ? player_in : player_q;

        // Step is sign-extended into a 9-bit signed sum so off-board moves show up negative.
        base      = (state_q == IDLE) ? {2'b00, start_d} : {2'b00, mem_addr_o};
        nxt       = base + {step_d[7], step_d};
        nxt_ok    = !nxt[8] && (nxt < CELLS);
        player_ok = (player_d == 2'b01) || (player_d == 2'b10);
        opponent  = player_q ^ 2'b11;

        state_d   = state_q;
        addr_d    = mem_addr_o;
        cnt_d     = cnt_q;
        opp_d     = opp_q;
        status_d  = dir_status_o;
        flip_d    = flip_cnt_o;
        done_d    = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    status_d = 1'b0;
                    flip_d   = '0;
                    if (player_ok && nxt_ok) begin
                        addr_d  = nxt[6:0];
                        cnt_d   = '0;
                        opp_d   = '0;
                        state_d = WAIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: state_d = CHECK;
            CHECK: begin
                if (mem_data_in == opponent) begin
                    opp_d = opp_q + 1'b1;
                    if ((cnt_q == WALK_LAST) || !nxt_ok) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = nxt[6:0];
                        cnt_d   = cnt_q + 1'b1;
                        state_d = WAIT;
                    end
                end else if ((mem_data_in == player_q) && (opp_q != '0)) begin
                    status_d = 1'b1;
                    flip_d   = 3'(opp_q);
                    state_d  = DONE;
                end else begin
                    status_d = 1'b0;
                    flip_d   = '0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // s_done_o is registered off DONE, so the pulse lands one cycle after the DONE state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            start_q      <= '0;
            player_q     <= '0;
            mem_addr_o   <= '0;
            cnt_q        <= '0;
            opp_q        <= '0;
            dir_status_o <= 1'b0;
            flip_cnt_o   <= '0;
            s_done_o     <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            start_q      <= start_d;
            player_q     <= player_d;
            mem_addr_o   <= addr_d;
            cnt_q        <= cnt_d;
            opp_q        <= opp_d;
            dir_status_o <= status_d;
            flip_cnt_o   <= flip_d;
            s_done_o     <= done_d;
        end
    end

endmodule

// File: tb/tb_dir_validator.sv
// Directed bench for dir_validator: walks across a modelled board with hand-computed
// latency, address and result expectations.
module tb_dir_validator;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ld = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] step_in = '0;
    logic [6:0] e_addr_in = '0;
    logic [1:0] player_in = '0;
    logic [1:0] mem_data_in = '0;
    logic [6:0] mem_addr_o;
    logic       s_done_o;
    logic       dir_status_o;
    logic [2:0] flip_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] board [0:127];

    dir_validator #(
        .BOARD_CELLS(100),
        .MAX_WALK   (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ld          (ld),
        .enable      (enable),
        .step_in     (step_in),
        .e_addr_in   (e_addr_in),
        .player_in   (player_in),
        .mem_data_in (mem_data_in),
        .mem_addr_o  (mem_addr_o),
        .s_done_o    (s_done_o),
        .dir_status_o(dir_status_o),
        .flip_cnt_o  (flip_cnt_o)
    );

    always #5 clock = ~clock;

    // Synchronous board memory: data valid one cycle after the address.
    always @(posedge clock) mem_data_in <= board[mem_addr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where s_done_o is seen (lat = edges after enable).
    task automatic run_walk(input bit do_ld, input logic [6:0] start, input logic [7:0] step,
                            input logic [1:0] player, output int lat,
                            output logic [6:0] a1, output logic [6:0] a3);
        ld        = do_ld;
        e_addr_in = start;
        step_in   = step;
        player_in = player;
        enable    = 1'b1;
        lat = -1;
        a1  = '0;
        a3  = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            ld     = 1'b0;
            enable = 1'b0;
            if (i == 1) a1 = mem_addr_o;
            if (i == 3) a3 = mem_addr_o;
            if (s_done_o) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        int         pulses;
        logic [6:0] a1, a3;

        for (int i = 0; i < 128; i++) board[i] = 2'b00;
        board[45] = 2'b10;
        board[46] = 2'b01;
        board[34] = 2'b00;
        board[10] = 2'b11;
        for (int r = 2; r <= 7; r++) board[r*10+1] = 2'b10;
        board[11] = 2'b01;
        board[1]  = 2'b11;

        repeat (2) @(negedge clock);
        check("rst_addr", mem_addr_o, 0);
        check("rst_done", s_done_o, 0);
        check("rst_dir", dir_status_o, 0);
        check("rst_flip", flip_cnt_o, 0);
        reset = 1'b1;
        @(negedge clock);

        // One opponent then own piece, ld and enable together
        run_walk(1'b1, 7'd44, 8'd1, 2'b01, lat, a1, a3);
        check("t1_lat", lat, 5);
        check("t1_addr1", a1, 45);
        check("t1_addr2", a3, 46);
        check("t1_dir", dir_status_o, 1);
        check("t1_flip", flip_cnt_o, 1);
        @(negedge clock);
        check("t1_done_once", s_done_o, 0);
        check("t1_dir_hold", dir_status_o, 1);
        check("t1_flip_hold", flip_cnt_o, 1);

        // Empty first cell, results clear from the previous walk
        run_walk(1'b1, 7'd44, 8'hF6, 2'b10, lat, a1, a3);
        check("t2_lat", lat, 3);
        check("t2_addr1", a1, 34);
        check("t2_dir", dir_status_o, 0);
        check("t2_flip", flip_cnt_o, 0);
        @(negedge clock);

        // Border first cell
        run_walk(1'b1, 7'd11, 8'hFF, 2'b01, lat, a1, a3);
        check("t3_lat", lat, 3);
        check("t3_addr1", a1, 10);
        check("t3_dir", dir_status_o, 0);
        @(negedge clock);

        // Start step off the board: no read, address held
        run_walk(1'b1, 7'd5, 8'hF6, 2'b01, lat, a1, a3);
        check("t3b_lat", lat, 1);
        check("t3b_addr_held", a1, 10);
        check("t3b_dir", dir_status_o, 0);
        @(negedge clock);

        // Six opponents bracketed
        run_walk(1'b1, 7'd81, 8'hF6, 2'b01, lat, a1, a3);
        check("t4_lat", lat, 15);
        check("t4_addr1", a1, 71);
        check("t4_addr2", a3, 61);
        check("t4_dir", dir_status_o, 1);
        check("t4_flip", flip_cnt_o, 6);
        @(negedge clock);

        // Seven opponents ending at the border
        board[11] = 2'b10;
        run_walk(1'b1, 7'd81, 8'hF6, 2'b01, lat, a1, a3);
        check("t4b_lat", lat, 17);
        check("t4b_dir", dir_status_o, 0);
        check("t4b_flip", flip_cnt_o, 0);
        @(negedge clock);

        // Opponent on last in-range cell, next step leaves the board
        board[1] = 2'b10;
        run_walk(1'b1, 7'd21, 8'hF6, 2'b01, lat, a1, a3);
        check("t5_lat", lat, 5);
        check("t5_dir", dir_status_o, 0);
        @(negedge clock);

        // Walk limit reached before the own piece at cell 1
        board[1]  = 2'b01;
        board[81] = 2'b10;
        run_walk(1'b1, 7'd91, 8'hF6, 2'b01, lat, a1, a3);
        check("t6_lat", lat, 17);
        check("t6_dir", dir_status_o, 0);
        check("t6_flip", flip_cnt_o, 0);
        @(negedge clock);

        run_walk(1'b1, 7'd44, 8'd1, 2'b01, lat, a1, a3);
        check("t6b_dir", dir_status_o, 1);
        @(negedge clock);

        // Invalid player: straight to done, address untouched
        run_walk(1'b1, 7'd44, 8'd1, 2'b00, lat, a1, a3);
        check("t7_lat", lat, 1);
        check("t7_addr_held", a1, 46);
        check("t7_dir", dir_status_o, 0);
        check("t7_flip", flip_cnt_o, 0);
        @(negedge clock);

        // ld/enable during CHECK ignored
        ld = 1'b1; e_addr_in = 7'd44; step_in = 8'd1; player_in = 2'b01; enable = 1'b1;
        @(negedge clock);
        ld = 1'b0; enable = 1'b0;
        @(negedge clock);
        ld = 1'b1; e_addr_in = 7'd5; step_in = 8'hF6; player_in = 2'b10; enable = 1'b1;
        @(negedge clock);
        ld = 1'b0; enable = 1'b0;
        check("t8_addr2", mem_addr_o, 46);
        lat = -1;
        for (int i = 4; i <= 60; i++) begin
            @(negedge clock);
            if (s_done_o) begin
                lat = i - 1;
                break;
            end
        end
        check("t8_lat", lat, 5);
        check("t8_dir", dir_status_o, 1);
        check("t8_flip", flip_cnt_o, 1);
        @(negedge clock);
        run_walk(1'b0, 7'd5, 8'hF6, 2'b10, lat, a1, a3);
        check("t8_noload_lat", lat, 5);
        check("t8_noload_dir", dir_status_o, 1);
        check("t8_noload_flip", flip_cnt_o, 1);
        @(negedge clock);

        // Reset while in WAIT
        ld = 1'b1; e_addr_in = 7'd44; step_in = 8'd1; player_in = 2'b01; enable = 1'b1;
        @(negedge clock);
        ld = 1'b0; enable = 1'b0;
        check("t9_addr_pre", mem_addr_o, 45);
        reset = 1'b0;
        #1;
        check("t9_rst_addr", mem_addr_o, 0);
        check("t9_rst_done", s_done_o, 0);
        check("t9_rst_dir", dir_status_o, 0);
        check("t9_rst_flip", flip_cnt_o, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (s_done_o) pulses++;
        end
        check("t9_no_done", pulses, 0);

        // After reset the loaded player is 00, so enable alone does nothing useful
        run_walk(1'b0, 7'd44, 8'd1, 2'b01, lat, a1, a3);
        check("t9_enable_only_lat", lat, 1);
        check("t9_enable_only_addr", a1, 0);
        check("t9_enable_only_dir", dir_status_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
